// File: rtl/cnt_sweep_ctrl.sv
// cnt_sweep_ctrl: sequencer driving one loadable up/down counter between two
// programmed bounds in one-shot, auto-reload or ping-pong fashion, with a
// step prescaler.
module cnt_sweep_ctrl #(
  parameter int unsigned N_BIT    = 8,
  parameter int unsigned DIV_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [N_BIT-1:0]    cfg_start,
  input  logic [N_BIT-1:0]    cfg_end,
  input  logic [1:0]          cfg_mode,
  input  logic [DIV_BITS-1:0] cfg_div,
  input  logic                start,
  input  logic                stop,
  output logic [N_BIT-1:0]    cnt,
  output logic                busy,
  output logic                dir,
  output logic                wrap,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

  // Datapath action selected by the FSM for the current cycle.
  typedef enum logic [2:0] {
    ACT_NONE, ACT_LOAD, ACT_STEP, ACT_FINISH, ACT_RELOAD, ACT_TURN
  } act_t;

  state_t state, state_nxt;
  act_t   act;

  logic [N_BIT-1:0]    start_r;
  logic [N_BIT-1:0]    end_r;
  logic [1:0]          mode_r;
  logic [DIV_BITS-1:0] div_r;
  logic [DIV_BITS-1:0] psc;
  // leg = 0 while heading from start towards end, 1 on the way back (ping-pong)
  logic                leg;

  logic                cfg_xfer;
  logic                tick;
  logic                at_target;
  logic                degen;
  logic [N_BIT-1:0]    target;

  // Handshake, prescaler tick and target decode.
  always_comb begin
    cfg_ready = (state != RUN);
    busy      = (state == RUN);
    cfg_xfer  = cfg_valid && cfg_ready;
    tick      = (psc == div_r);
    target    = leg ? start_r : end_r;
    at_target = (cnt == target);
    degen     = (start_r == end_r);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath action; in RUN stop beats start beats tick.
  always_comb begin
    state_nxt = state;
    act       = ACT_NONE;
    case (state)
      IDLE: begin
        if (cfg_xfer) state_nxt = ARMED;
      end
      ARMED, DONE: begin
        if (cfg_xfer) begin
          state_nxt = ARMED;
        end else if (start) begin
          state_nxt = RUN;
          act       = ACT_LOAD;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = ARMED;
        end else if (start) begin
          act = ACT_LOAD;
        end else if (tick) begin
          if (!at_target) begin
            act = ACT_STEP;
          end else begin
            case (mode_r)
              2'd1: act = ACT_RELOAD;
              // A degenerate ping-pong has nowhere to turn: behave as reload.
              2'd2: act = degen ? ACT_RELOAD : ACT_TURN;
              default: begin
                act       = ACT_FINISH;
                state_nxt = DONE;
              end
            endcase
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Configuration registers, counter, direction, prescaler and event pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_r <= '0;
      end_r   <= '0;
      mode_r  <= '0;
      div_r   <= '0;
      psc     <= '0;
      leg     <= 1'b0;
      cnt     <= '0;
      dir     <= 1'b0;
      wrap    <= 1'b0;
      done    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      done <= 1'b0;
      if (cfg_xfer) begin
        start_r <= cfg_start;
        end_r   <= cfg_end;
        mode_r  <= cfg_mode;
        div_r   <= cfg_div;
      end
      case (act)
        ACT_LOAD: begin
          cnt <= start_r;
          dir <= (end_r < start_r);
          leg <= 1'b0;
          psc <= '0;
        end
        ACT_STEP: begin
          cnt <= dir ? cnt - 1'b1 : cnt + 1'b1;
          psc <= '0;
        end
        ACT_FINISH: begin
          done <= 1'b1;
          psc  <= '0;
        end
        ACT_RELOAD: begin
          cnt  <= start_r;
          wrap <= 1'b1;
          psc  <= '0;
        end
        ACT_TURN: begin
          // Step in the new direction on the same tick as the reversal.
          cnt  <= dir ? cnt + 1'b1 : cnt - 1'b1;
          dir  <= ~dir;
          leg  <= ~leg;
          wrap <= 1'b1;
          psc  <= '0;
        end
        default: begin
          if (state == RUN) psc <= psc + 1'b1;
        end
      endcase
    end
  end

endmodule
